// File: rtl/pwm_cmd_sequencer.sv
// pwm_cmd_sequencer: decodes SPI command frames into per-channel shadow thresholds
// and sweeps them onto the PWM bank starting at the overflow after a commit.
module pwm_cmd_sequencer #(
    parameter int pwm_width   = 8,
    parameter int num_pwm     = 12,
    parameter int frame_width = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [frame_width-1:0] frame_data,
    input  logic                   frame_valid,
    input  logic                   overflow,
    output logic [pwm_width-1:0]   new_thres,
    output logic [num_pwm-1:0]     set_thres,
    output logic                   busy,
    output logic                   frame_err
);
    localparam int iw = $clog2(num_pwm + 1);
    typedef enum logic [1:0] {IDLE, ARMED, SWEEP} state_t;
    state_t state, state_next;
    logic [iw-1:0] idx, ch;
    logic pending;
    logic [pwm_width-1:0] shadow [num_pwm];
    logic [num_pwm-1:0] dirty, strobe;
    logic [7:0] cmd;
    logic [pwm_width-1:0] data, sample_thres;
    logic wr_ch, wr_all, commit, sample, last;

    assign cmd = frame_data[frame_width-1 -: 8];
    assign data = frame_data[pwm_width-1:0];
    assign wr_ch = frame_valid && ({24'd0, cmd} < num_pwm);
    assign wr_all = frame_valid && cmd == 8'hF0;
    assign commit = frame_valid && cmd == 8'hFF;
    assign last = idx == iw'(num_pwm);
    // the overflow edge itself samples channel 0, so channel i appears i+1 cycles later
    assign sample = (state == ARMED && overflow) || (state == SWEEP && !last);
    assign ch = state == ARMED ? '0 : idx;
    assign busy = state != IDLE || pending;

    always_comb begin
        sample_thres = '0;
        strobe = '0;
        for (int i = 0; i < num_pwm; i++)
            if (ch == iw'(i)) begin
                sample_thres = shadow[i];
                strobe[i] = sample && dirty[i];
            end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = pending ? ARMED : IDLE;
            ARMED:   state_next = overflow ? SWEEP : ARMED;
            SWEEP:   state_next = last ? (pending ? ARMED : IDLE) : SWEEP;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset)
            state <= IDLE;
        else
            state <= state_next;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            idx <= '0;
            pending <= 1'b0;
            new_thres <= '0;
            set_thres <= '0;
            frame_err <= 1'b0;
        end else begin
            idx <= sample ? ch + 1'b1 : idx;
            pending <= commit || (pending && !(state == ARMED && overflow));
            new_thres <= sample ? sample_thres : new_thres;
            set_thres <= strobe;
            frame_err <= frame_valid && !(wr_ch || wr_all || commit);
        end

    // a write in the same cycle as the sweep's sample keeps the channel dirty
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            for (int i = 0; i < num_pwm; i++)
                shadow[i] <= '0;
            dirty <= '0;
        end else
            for (int i = 0; i < num_pwm; i++) begin
                if (sample && ch == iw'(i))
                    dirty[i] <= 1'b0;
                if (wr_all || (wr_ch && cmd == 8'(i))) begin
                    shadow[i] <= data;
                    dirty[i] <= 1'b1;
                end
            end
endmodule

// File: doc/pwm_cmd_sequencer.md
Name: pwm_cmd_sequencer

Overview:
- Command stage between the SPI slave and the PWM channel bank.
- Decodes completed SPI frames into per-channel shadow thresholds.
- On a commit command, waits for the next PWM counter overflow, then sweeps the channels and drives the shared new_thres/set_thres bus of the pwm instances.
- All channels change within the same PWM period, so multi-channel updates are glitch-free.

Parameters:
- pwm_width, 8, threshold width; also the data field width of a frame.
- num_pwm, 12, number of PWM channels; constraint 1 <= num_pwm < 2**pwm_width.
- frame_width, 16, SPI frame width = 8 + roundup8(pwm_width).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- frame_data  input  frame_width  completed SPI frame; bits [frame_width-1:frame_width-8] = cmd byte, bits [pwm_width-1:0] = data.
- frame_valid  input  1  one-cycle pulse in clk domain; frame_data is valid in that cycle.
- overflow  input  1  one-cycle pulse from the PWM counter at wrap.
- new_thres  output  pwm_width  threshold to load into the selected channel.
- set_thres  output  num_pwm  one-hot load strobe per channel.
- busy  output  1  high while a commit is pending or a sweep is running.
- frame_err  output  1  one-cycle pulse on an unrecognised cmd byte.

Behaviour:
- Reset (async, active-high) clears:
  - all shadow regs and dirty bits to 0; pending to 0;
  - state to IDLE;
  - new_thres, set_thres, busy and frame_err to 0.
  - Reset during a sweep aborts it; no further set_thres is issued.
- Commands, acted on in the cycle frame_valid=1 and visible from the next cycle:
  - cmd 0x00..num_pwm-1: shadow[cmd] <= data; dirty[cmd] <= 1.
  - cmd 0xF0 (broadcast): every shadow <= data; every dirty bit <= 1.
  - cmd 0xFF (commit): pending <= 1.
  - Any other cmd, including num_pwm..0xEF: no state change; frame_err=1 in the next cycle.
- States:
  - IDLE: pending=1 -> ARMED.
  - ARMED: overflow=1 -> SWEEP with idx=0, pending cleared in the same cycle.
    - A commit and an overflow in the same cycle: the commit is latched and does not consume that overflow; it waits for the following one.
  - SWEEP: one channel per cycle, idx = 0..num_pwm-1. Outputs are registered.
    - If overflow=1 in cycle N, channel i is presented in cycle N+1+i: new_thres=shadow[i], and set_thres=(1<<i) only if dirty[i]=1, else 0. dirty[i] is cleared.
    - After idx=num_pwm-1 -> ARMED if pending=1, else IDLE.
- set_thres is all-zero outside SWEEP.
- new_thres holds its last value outside SWEEP.
- busy = (state != IDLE) | pending.
- Write/sweep collision: a write to channel i in the cycle the sweep samples i is handled as follows:
  - the sweep outputs the old shadow value;
  - dirty[i] stays 1, because the write wins over the clear;
  - the new value goes out on the next committed sweep.
- Writes to a channel the sweep has not yet reached appear in the current sweep.
- Commit during SWEEP: pending is set, and the block re-arms for the next overflow after the sweep.
- Repeated commit while ARMED: no additional effect.
- A sweep always finishes before the next overflow (guaranteed by num_pwm < 2**pwm_width).
- Implementation budget: shadow array is num_pwm x pwm_width flops; no RAM required.

Test Plan:
- Reset, then write cmd 0x03 data 0x80, then commit; overflow in cycle N. Required: exactly one strobe, set_thres=0x008 with new_thres=0x80 in cycle N+4; busy falls after cycle N+12.
- Broadcast 0xF0 data 0x40, then commit, then overflow. Required: set_thres walks 0x001..0x800 on 12 consecutive cycles, new_thres=0x40 each cycle; a second commit+overflow with no writes produces no strobes.
- Commit arriving in the same cycle as overflow. Required: no sweep on that overflow; sweep starts on the next overflow.
- Write ch5=0x11 and commit; during the sweep, write ch5=0x22 in the cycle idx=5, and ch9=0x33 at idx=2. Required: ch5 gets 0x11 and ch9 gets 0x33 in this sweep; the next commit sweep strobes only ch5, with 0x22.
- Frames with cmd 0x0C and 0x7F. Required: frame_err pulses once each, shadows unchanged; a subsequent commit+overflow produces no strobes.
- Assert reset at idx=4 of a sweep. Required: outputs go to 0 immediately; after release there are no strobes and busy=0, even on later overflows until a new write+commit.
